// File: rtl/xadac_vload.sv
// xadac vector load unit: scoreboarded single-beat AXI reads returning masked vectors.
// Requests may complete out of order; the lowest eligible id wins each arbitration.
module xadac_vload #(
    parameter int unsigned SbLen       = 4,
    parameter int unsigned IdWidth     = $clog2(SbLen),
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned ElemWidth   = 8,
    parameter int unsigned VecLen      = 4,
    parameter int unsigned DataWidth   = ElemWidth * VecLen,
    parameter int unsigned VecLenWidth = $clog2(VecLen + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   exe_req_valid_i,
    output logic                   exe_req_ready_o,
    input  logic [IdWidth-1:0]     exe_req_id_i,
    input  logic [AddrWidth-1:0]   exe_req_addr_i,
    input  logic [VecLenWidth-1:0] exe_req_vlen_i,

    output logic                   exe_rsp_valid_o,
    input  logic                   exe_rsp_ready_i,
    output logic [IdWidth-1:0]     exe_rsp_id_o,
    output logic [DataWidth-1:0]   exe_rsp_data_o,

    output logic [IdWidth-1:0]     axi_ar_id_o,
    output logic [AddrWidth-1:0]   axi_ar_addr_o,
    output logic                   axi_ar_valid_o,
    input  logic                   axi_ar_ready_i,

    input  logic [IdWidth-1:0]     axi_r_id_i,
    input  logic [DataWidth-1:0]   axi_r_data_i,
    input  logic                   axi_r_valid_i,
    output logic                   axi_r_ready_o
);

    // Scoreboard state
    logic [SbLen-1:0]       req_done_q, req_done_d;
    logic [SbLen-1:0]       ar_done_q, ar_done_d;
    logic [SbLen-1:0]       r_done_q, r_done_d;
    logic [SbLen-1:0]       rsp_done_q, rsp_done_d;
    logic [AddrWidth-1:0]   addr_q [SbLen];
    logic [AddrWidth-1:0]   addr_d [SbLen];
    logic [VecLenWidth-1:0] vlen_q [SbLen];
    logic [VecLenWidth-1:0] vlen_d [SbLen];
    logic [DataWidth-1:0]   data_q [SbLen];
    logic [DataWidth-1:0]   data_d [SbLen];

    // Output registers
    logic                 ar_valid_q, ar_valid_d;
    logic [IdWidth-1:0]   ar_id_q, ar_id_d;
    logic [AddrWidth-1:0] ar_addr_q, ar_addr_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IdWidth-1:0]   rsp_id_q, rsp_id_d;
    logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
    logic                 r_ready_q;

    logic                 req_fire, ar_fire, r_fire, r_hit, rsp_fire;
    logic [SbLen-1:0]     req_set, r_set, ar_cand, rsp_cand;
    logic [IdWidth-1:0]   ar_sel, rsp_sel;
    logic [DataWidth-1:0] r_masked;

    function automatic logic [IdWidth-1:0] lowest_idx(input logic [SbLen-1:0] vec);
        lowest_idx = '0;
        for (int i = int'(SbLen) - 1; i >= 0; i--) begin
            if (vec[i]) lowest_idx = IdWidth'(i);
        end
    endfunction

    // Elements at or beyond the requested count read back as zero.
    function automatic logic [DataWidth-1:0] mask_vec(input logic [DataWidth-1:0]   d,
                                                      input logic [VecLenWidth-1:0] n);
        mask_vec = '0;
        for (int i = 0; i < int'(VecLen); i++) begin
            if (VecLenWidth'(i) < n) mask_vec[i*ElemWidth +: ElemWidth] = d[i*ElemWidth +: ElemWidth];
        end
    endfunction

    assign exe_req_ready_o = !req_done_q[exe_req_id_i];
    assign exe_rsp_valid_o = rsp_valid_q;
    assign exe_rsp_id_o    = rsp_id_q;
    assign exe_rsp_data_o  = rsp_data_q;
    assign axi_ar_valid_o  = ar_valid_q;
    assign axi_ar_id_o     = ar_id_q;
    assign axi_ar_addr_o   = ar_addr_q;
    assign axi_r_ready_o   = r_ready_q;

    assign req_fire = exe_req_valid_i && exe_req_ready_o;
    assign ar_fire  = ar_valid_q && axi_ar_ready_i;
    assign r_fire   = axi_r_valid_i && r_ready_q;
    assign r_hit    = r_fire && ar_done_q[axi_r_id_i] && !r_done_q[axi_r_id_i];
    assign rsp_fire = rsp_valid_q && exe_rsp_ready_i;
    assign r_masked = mask_vec(axi_r_data_i, vlen_q[axi_r_id_i]);

    always_comb begin
        req_done_d  = req_done_q;
        ar_done_d   = ar_done_q;
        r_done_d    = r_done_q;
        rsp_done_d  = rsp_done_q;
        addr_d      = addr_q;
        vlen_d      = vlen_q;
        data_d      = data_q;
        ar_valid_d  = ar_valid_q;
        ar_id_d     = ar_id_q;
        ar_addr_d   = ar_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        req_set     = '0;
        r_set       = '0;
        ar_sel      = '0;
        rsp_sel     = '0;

        if (req_fire) begin
            req_set[exe_req_id_i] = 1'b1;
            req_done_d[exe_req_id_i] = 1'b1;
            addr_d[exe_req_id_i] = exe_req_addr_i;
            vlen_d[exe_req_id_i] = exe_req_vlen_i;
        end

        if (r_hit) begin
            r_set[axi_r_id_i] = 1'b1;
            r_done_d[axi_r_id_i] = 1'b1;
            data_d[axi_r_id_i] = r_masked;
        end

        // A request accepted this cycle can be issued on AR straight away.
        ar_cand = (req_done_q | req_set) & ~ar_done_q;
        if (!ar_valid_q || ar_fire) begin
            ar_valid_d = |ar_cand;
            if (|ar_cand) begin
                ar_sel    = lowest_idx(ar_cand);
                ar_id_d   = ar_sel;
                ar_addr_d = (req_fire && exe_req_id_i == ar_sel) ? exe_req_addr_i : addr_q[ar_sel];
                ar_done_d[ar_sel] = 1'b1;
            end
        end

        // Likewise a beat arriving this cycle can be returned next cycle.
        rsp_cand = (r_done_q | r_set) & ~rsp_done_q;
        if (!rsp_valid_q || rsp_fire) begin
            rsp_valid_d = |rsp_cand;
            if (|rsp_cand) begin
                rsp_sel    = lowest_idx(rsp_cand);
                rsp_id_d   = rsp_sel;
                rsp_data_d = (r_hit && axi_r_id_i == rsp_sel) ? r_masked : data_q[rsp_sel];
                rsp_done_d[rsp_sel] = 1'b1;
            end
        end

        if (rsp_fire) begin
            req_done_d[rsp_id_q] = 1'b0;
            ar_done_d[rsp_id_q]  = 1'b0;
            r_done_d[rsp_id_q]   = 1'b0;
            rsp_done_d[rsp_id_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_done_q  <= '0;
            ar_done_q   <= '0;
            r_done_q    <= '0;
            rsp_done_q  <= '0;
            ar_valid_q  <= 1'b0;
            ar_id_q     <= '0;
            ar_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            r_ready_q   <= 1'b0;
        end else begin
            req_done_q  <= req_done_d;
            ar_done_q   <= ar_done_d;
            r_done_q    <= r_done_d;
            rsp_done_q  <= rsp_done_d;
            ar_valid_q  <= ar_valid_d;
            ar_id_q     <= ar_id_d;
            ar_addr_q   <= ar_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            r_ready_q   <= 1'b1;
        end
    end

    // Payload storage is only meaningful while its flags say so; no reset needed.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        vlen_q <= vlen_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_xadac_vload.sv
// Bench for xadac_vload: directed scenarios followed by randomized traffic checked
// against a scoreboard-level model of the load unit.
module tb_xadac_vload;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exe_req_valid_i;
    logic        exe_req_ready_o;
    logic [1:0]  exe_req_id_i;
    logic [31:0] exe_req_addr_i;
    logic [2:0]  exe_req_vlen_i;
    logic        exe_rsp_valid_o;
    logic        exe_rsp_ready_i;
    logic [1:0]  exe_rsp_id_o;
    logic [31:0] exe_rsp_data_o;
    logic [1:0]  axi_ar_id_o;
    logic [31:0] axi_ar_addr_o;
    logic        axi_ar_valid_o;
    logic        axi_ar_ready_i;
    logic [1:0]  axi_r_id_i;
    logic [31:0] axi_r_data_i;
    logic        axi_r_valid_i;
    logic        axi_r_ready_o;

    int total = 0;
    int bad = 0;

    // Model state for randomized traffic
    int          m_busy [4];
    int          m_ar [4];
    int          m_r [4];
    logic [31:0] m_addr [4];
    int          m_vlen [4];
    int          rq[$];
    int          n_req, n_rsp;

    xadac_vload dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .exe_req_valid_i (exe_req_valid_i),
        .exe_req_ready_o (exe_req_ready_o),
        .exe_req_id_i    (exe_req_id_i),
        .exe_req_addr_i  (exe_req_addr_i),
        .exe_req_vlen_i  (exe_req_vlen_i),
        .exe_rsp_valid_o (exe_rsp_valid_o),
        .exe_rsp_ready_i (exe_rsp_ready_i),
        .exe_rsp_id_o    (exe_rsp_id_o),
        .exe_rsp_data_o  (exe_rsp_data_o),
        .axi_ar_id_o     (axi_ar_id_o),
        .axi_ar_addr_o   (axi_ar_addr_o),
        .axi_ar_valid_o  (axi_ar_valid_o),
        .axi_ar_ready_i  (axi_ar_ready_i),
        .axi_r_id_i      (axi_r_id_i),
        .axi_r_data_i    (axi_r_data_i),
        .axi_r_valid_i   (axi_r_valid_i),
        .axi_r_ready_o   (axi_r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic [31:0] mask_model(input logic [31:0] d, input int n);
        if (n >= 4) return d;
        return d & ((32'd1 << (8 * n)) - 32'd1);
    endfunction

    task automatic req(input int id, input logic [31:0] addr, input int vlen);
        exe_req_valid_i = 1'b1;
        exe_req_id_i    = 2'(id);
        exe_req_addr_i  = addr;
        exe_req_vlen_i  = 3'(vlen);
    endtask

    task automatic check_ar(input string tag, input int id, input logic [31:0] addr);
        check({tag, "_arv"}, axi_ar_valid_o, 1);
        check({tag, "_arid"}, axi_ar_id_o, 64'(id));
        check({tag, "_aradr"}, axi_ar_addr_o, addr);
    endtask

    // Drive one R beat with the response channel ready; the response follows one cycle later.
    task automatic r_then_rsp(input int id, input logic [31:0] d, input logic [31:0] exp,
                              input string tag);
        axi_r_valid_i   = 1'b1;
        axi_r_id_i      = 2'(id);
        axi_r_data_i    = d;
        exe_rsp_ready_i = 1'b1;
        tick();
        axi_r_valid_i = 1'b0;
        check({tag, "_rspv"}, exe_rsp_valid_o, 1);
        check({tag, "_rspid"}, exe_rsp_id_o, 64'(id));
        check({tag, "_rspd"}, exe_rsp_data_o, exp);
    endtask

    task automatic single(input int id, input logic [31:0] addr, input int vlen,
                          input logic [31:0] rdata, input logic [31:0] exp, input string tag);
        req(id, addr, vlen);
        axi_ar_ready_i = 1'b1;
        #1;
        check({tag, "_rdy"}, exe_req_ready_o, 1);
        tick();
        exe_req_valid_i = 1'b0;
        check_ar(tag, id, addr);
        tick();
        check({tag, "_ardone"}, axi_ar_valid_o, 0);
        r_then_rsp(id, rdata, exp, tag);
        tick();
        check({tag, "_idle"}, exe_rsp_valid_o, 0);
    endtask

    initial begin
        int drain, req_acc, ridx, rid, sid, aid;
        int ar_hold, rsp_hold;
        logic [1:0]  h_ar_id, h_rsp_id;
        logic [31:0] h_ar_addr, h_rsp_data;

        rst_i           = 1'b1;
        exe_req_valid_i = 1'b0;
        exe_req_id_i    = '0;
        exe_req_addr_i  = '0;
        exe_req_vlen_i  = '0;
        exe_rsp_ready_i = 1'b0;
        axi_ar_ready_i  = 1'b0;
        axi_r_id_i      = '0;
        axi_r_data_i    = '0;
        axi_r_valid_i   = 1'b0;
        tick();
        tick();
        check("rst_rspv", exe_rsp_valid_o, 0);
        check("rst_rspid", exe_rsp_id_o, 0);
        check("rst_rspd", exe_rsp_data_o, 0);
        check("rst_arv", axi_ar_valid_o, 0);
        check("rst_arid", axi_ar_id_o, 0);
        check("rst_aradr", axi_ar_addr_o, 0);
        check("rst_rrdy", axi_r_ready_o, 0);
        check("rst_reqrdy", exe_req_ready_o, 1);
        rst_i = 1'b0;
        tick();
        check("rrdy_after_rst", axi_r_ready_o, 1);

        single(0, 32'h0000_1000, 4, 32'h4433_2211, 32'h4433_2211, "single");
        single(1, 32'h0000_1040, 2, 32'hDDCC_BBAA, 32'h0000_BBAA, "mask2");
        single(2, 32'h0000_1080, 0, 32'hDDCC_BBAA, 32'h0000_0000, "mask0");
        single(3, 32'h0000_10C0, 7, 32'h8765_4321, 32'h8765_4321, "mask7");

        // Out of order: AR in id order, responses follow R order
        axi_ar_ready_i = 1'b1;
        req(0, 32'h0000_2000, 4);
        tick();
        check_ar("ooo0", 0, 32'h0000_2000);
        req(1, 32'h0000_2100, 4);
        tick();
        check_ar("ooo1", 1, 32'h0000_2100);
        req(2, 32'h0000_2200, 3);
        tick();
        exe_req_valid_i = 1'b0;
        check_ar("ooo2", 2, 32'h0000_2200);
        tick();
        check("ooo_ardone", axi_ar_valid_o, 0);
        r_then_rsp(2, 32'hA2A2_A2A2, 32'h00A2_A2A2, "ooo_r2");
        r_then_rsp(0, 32'hA0A0_A0A0, 32'hA0A0_A0A0, "ooo_r0");
        r_then_rsp(1, 32'hA1A1_A1A1, 32'hA1A1_A1A1, "ooo_r1");
        tick();
        check("ooo_idle", exe_rsp_valid_o, 0);

        // Backpressure on AR and on the response channel
        axi_ar_ready_i  = 1'b0;
        exe_rsp_ready_i = 1'b0;
        req(3, 32'h0000_3300, 4);
        tick();
        req(0, 32'h0000_3000, 1);
        tick();
        exe_req_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_ar("bp_arhold", 3, 32'h0000_3300);
            tick();
        end
        axi_ar_ready_i = 1'b1;
        tick();
        check_ar("bp_ar0", 0, 32'h0000_3000);
        tick();
        check("bp_ardone", axi_ar_valid_o, 0);
        axi_r_valid_i = 1'b1;
        axi_r_id_i    = 2'd3;
        axi_r_data_i  = 32'h1313_1313;
        tick();
        axi_r_id_i   = 2'd0;
        axi_r_data_i = 32'h1010_1010;
        tick();
        axi_r_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp_rsphold_v", exe_rsp_valid_o, 1);
            check("bp_rsphold_id", exe_rsp_id_o, 3);
            check("bp_rsphold_d", exe_rsp_data_o, 32'h1313_1313);
            tick();
        end
        exe_rsp_ready_i = 1'b1;
        tick();
        check("bp_rsp0_v", exe_rsp_valid_o, 1);
        check("bp_rsp0_id", exe_rsp_id_o, 0);
        check("bp_rsp0_d", exe_rsp_data_o, 32'h0000_0010);
        tick();
        check("bp_idle", exe_rsp_valid_o, 0);

        // Full scoreboard and id reuse
        for (int i = 0; i < 4; i++) begin
            req(i, 32'h0000_4000 + 32'(i) * 32'h100, 4);
            tick();
        end
        exe_req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exe_req_id_i = 2'(i);
            #1;
            check("full_busy", exe_req_ready_o, 0);
        end
        tick();
        tick();
        check("full_ardone", axi_ar_valid_o, 0);
        r_then_rsp(1, 32'h5151_5151, 32'h5151_5151, "reuse_r1");
        req(1, 32'h0000_4444, 2);
        #1;
        check("reuse_busy", exe_req_ready_o, 0);
        tick();
        check("reuse_free", exe_req_ready_o, 1);
        check("reuse_rspgone", exe_rsp_valid_o, 0);
        tick();
        exe_req_valid_i = 1'b0;
        check_ar("reuse_ar", 1, 32'h0000_4444);
        tick();
        r_then_rsp(0, 32'h6060_6060, 32'h6060_6060, "full_r0");
        r_then_rsp(2, 32'h6262_6262, 32'h6262_6262, "full_r2");
        r_then_rsp(3, 32'h6363_6363, 32'h6363_6363, "full_r3");
        r_then_rsp(1, 32'hCAFE_BABE, 32'h0000_BABE, "full_r1");
        tick();
        check("full_idle", exe_rsp_valid_o, 0);

        // Reset with requests in flight
        req(0, 32'h0000_5000, 4);
        tick();
        req(1, 32'h0000_5100, 4);
        tick();
        exe_req_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mrst_arv", axi_ar_valid_o, 0);
        check("mrst_arid", axi_ar_id_o, 0);
        check("mrst_aradr", axi_ar_addr_o, 0);
        check("mrst_rspv", exe_rsp_valid_o, 0);
        check("mrst_rspid", exe_rsp_id_o, 0);
        check("mrst_rspd", exe_rsp_data_o, 0);
        check("mrst_rrdy", axi_r_ready_o, 0);
        check("mrst_reqrdy", exe_req_ready_o, 1);
        tick();
        check("mrst_rrdy1", axi_r_ready_o, 1);
        axi_r_valid_i   = 1'b1;
        axi_r_id_i      = 2'd0;
        axi_r_data_i    = 32'hDEAD_BEEF;
        exe_rsp_ready_i = 1'b1;
        tick();
        axi_r_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("mrst_norsp", exe_rsp_valid_o, 0);
            check("mrst_noar", axi_ar_valid_o, 0);
            tick();
        end
        single(0, 32'h0000_6000, 4, 32'h7766_5544, 32'h7766_5544, "post_rst");

        // Randomized traffic against the scoreboard model
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 0;
            m_ar[i]   = 0;
            m_r[i]    = 0;
        end
        n_req    = 0;
        n_rsp    = 0;
        ar_hold  = 0;
        rsp_hold = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            drain = (cyc >= 450) ? 1 : 0;
            exe_req_valid_i = (drain == 0) && ($urandom_range(0, 2) != 0);
            exe_req_id_i    = 2'($urandom_range(0, 3));
            exe_req_addr_i  = $urandom;
            exe_req_vlen_i  = 3'($urandom_range(0, 7));
            axi_ar_ready_i  = (drain != 0) || ($urandom_range(0, 3) != 0);
            exe_rsp_ready_i = (drain != 0) || ($urandom_range(0, 3) != 0);
            axi_r_valid_i   = 1'b0;
            ridx = -1;
            rid  = 0;
            if (rq.size() > 0 && ((drain != 0) || $urandom_range(0, 2) != 0)) begin
                ridx = int'($urandom_range(0, rq.size() - 1));
                rid  = rq[ridx];
                axi_r_valid_i = 1'b1;
                axi_r_id_i    = 2'(rid);
                axi_r_data_i  = mem_word(m_addr[rid]);
            end
            #1;
            if (ar_hold != 0) begin
                check("rnd_arhold_v", axi_ar_valid_o, 1);
                check("rnd_arhold_id", axi_ar_id_o, h_ar_id);
                check("rnd_arhold_adr", axi_ar_addr_o, h_ar_addr);
            end
            if (rsp_hold != 0) begin
                check("rnd_rsphold_v", exe_rsp_valid_o, 1);
                check("rnd_rsphold_id", exe_rsp_id_o, h_rsp_id);
                check("rnd_rsphold_d", exe_rsp_data_o, h_rsp_data);
            end
            sid = int'(exe_req_id_i);
            req_acc = (exe_req_valid_i && m_busy[sid] == 0) ? 1 : 0;
            if (exe_req_valid_i) check("rnd_reqrdy", exe_req_ready_o, (m_busy[sid] == 0) ? 1 : 0);

            aid = int'(axi_ar_id_o);
            if (axi_ar_valid_o && axi_ar_ready_i) begin
                check("rnd_ar_pend", (m_busy[aid] != 0 && m_ar[aid] == 0) ? 1 : 0, 1);
                check("rnd_ar_adr", axi_ar_addr_o, m_addr[aid]);
                m_ar[aid] = 1;
                rq.push_back(aid);
            end
            if (axi_r_valid_i && axi_r_ready_o && ridx >= 0) begin
                rq.delete(ridx);
                m_r[rid] = 1;
            end
            if (exe_rsp_valid_o && exe_rsp_ready_i) begin
                aid = int'(exe_rsp_id_o);
                check("rnd_rsp_rdone", m_r[aid], 1);
                check("rnd_rsp_d", exe_rsp_data_o, mask_model(mem_word(m_addr[aid]), m_vlen[aid]));
                m_busy[aid] = 0;
                m_ar[aid]   = 0;
                m_r[aid]    = 0;
                n_rsp++;
            end
            if (req_acc != 0) begin
                m_busy[sid] = 1;
                m_ar[sid]   = 0;
                m_r[sid]    = 0;
                m_addr[sid] = exe_req_addr_i;
                m_vlen[sid] = int'(exe_req_vlen_i);
                n_req++;
            end
            ar_hold    = (axi_ar_valid_o && !axi_ar_ready_i) ? 1 : 0;
            h_ar_id    = axi_ar_id_o;
            h_ar_addr  = axi_ar_addr_o;
            rsp_hold   = (exe_rsp_valid_o && !exe_rsp_ready_i) ? 1 : 0;
            h_rsp_id   = exe_rsp_id_o;
            h_rsp_data = exe_rsp_data_o;
            @(posedge clk_i);
            #1;
        end
        exe_req_valid_i = 1'b0;
        axi_r_valid_i   = 1'b0;
        check("rnd_drain", n_rsp, n_req);
        check("rnd_rq_empty", rq.size(), 0);
        check("rnd_final_rspv", exe_rsp_valid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xadac_vload.md
# xadac_vload

Vector load unit of the xadac coprocessor: accepts execute requests carrying a base address and an element count, fetches one vector per request over a single-beat AXI read (AR/R), zeroes elements beyond the count, and returns the vector as an execute response for write-back to the vector register file. It is the memory-side producer of vector operands consumed by the MAC and activation/store stages. Up to SbLen requests are outstanding, tracked in a scoreboard indexed by request id; responses may complete out of order.

## Interface

- SbLen, 4, scoreboard depth; request ids are 0..SbLen-1
- IdWidth, $clog2(SbLen), width of request id and AXI id
- AddrWidth, 32, address width
- ElemWidth, 8, bits per vector element
- VecLen, 4, elements per vector; DataWidth = ElemWidth*VecLen
- VecLenWidth, $clog2(VecLen+1), width of element-count field

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- exe_req_valid  in  1  request valid
- exe_req_ready  out  1  request accepted when valid&&ready
- exe_req_id  in  IdWidth  request id / scoreboard index
- exe_req_addr  in  AddrWidth  vector base address
- exe_req_vlen  in  VecLenWidth  number of valid elements
- exe_rsp_valid  out  1  response valid (registered)
- exe_rsp_ready  in  1  response consumed when valid&&ready
- exe_rsp_id  out  IdWidth  id of completed request
- exe_rsp_data  out  DataWidth  loaded, masked vector
- axi_ar_id  out  IdWidth  read id (= request id)
- axi_ar_addr  out  AddrWidth  read address
- axi_ar_valid  out  1  read address valid (registered)
- axi_ar_ready  in  1  read address ready
- axi_r_id  in  IdWidth  read data id
- axi_r_data  in  DataWidth  read data
- axi_r_valid  in  1  read data valid
- axi_r_ready  out  1  read data ready (registered)

## Operation

- Scoreboard entry per id: addr, vlen, data, flags req_done, ar_done, r_done, rsp_done. Entry busy iff req_done.
- exe_req_ready = !busy[exe_req_id] (combinational). On handshake: store addr, vlen; set req_done.
- AR: if axi_ar_valid clear or handshaking this cycle, select lowest id with req_done && !ar_done (including an entry accepted this cycle); load axi_ar_id/addr, set ar_done, assert axi_ar_valid next cycle. Address passed unchanged.
- R: axi_r_ready = 1 from first cycle after reset. On R handshake for entry with ar_done && !r_done: data[i] = (i < vlen) ? r_data element i : 0; set r_done. Beats for any other id are dropped without state change.
- vlen >= VecLen keeps all elements; vlen = 0 still issues AR and returns all-zero data.
- RSP: if exe_rsp_valid clear or handshaking this cycle, select lowest id with r_done && !rsp_done, register id/data, set rsp_done. On rsp handshake the entry is cleared to idle (all flags 0).
- Outputs held stable while valid && !ready (AXI/xadac rule).

## Timing

- Reset: all entries idle; exe_rsp_valid, exe_rsp_id, exe_rsp_data, axi_ar_valid, axi_ar_id, axi_ar_addr, axi_r_ready = 0; exe_req_ready reflects empty scoreboard (1).
- Request accepted at T -> axi_ar_valid at T+1 at earliest.
- R handshake at U -> exe_rsp_valid at U+1 at earliest.
- Back-to-back: one AR and one response per cycle sustained.
- Entry freed by rsp handshake at V; same id accepted again at V+1 earliest (busy during V).
- Simultaneous accept of id A and R for id B: both processed same cycle.
- rst asserted mid-operation: all state dropped next edge; later R beats ignored; no response emitted for lost requests.

## Test plan

- Single: id=0, addr=0x1000, vlen=4; AR ready immediately; R id=0 data=0x44332211 -> AR at T+1 addr 0x1000 id 0; rsp id 0 data 0x44332211 one cycle after R.
- Masking: vlen=2, R data 0xDDCCBBAA -> rsp data 0x0000BBAA; vlen=0 -> 0x00000000; vlen=7 -> unmasked.
- Out of order: ids 0,1,2 issued back-to-back, R returns 2,0,1 -> rsp order 2,0,1 with correct data; AR order 0,1,2.
- Backpressure: axi_ar_ready low 5 cycles, exe_rsp_ready low 3 cycles -> outputs held stable, no loss, no duplication.
- Full/reuse: 4 requests outstanding -> exe_req_ready=0 for each busy id; after rsp of id 1, id 1 re-accepted next cycle, not same cycle.
- Reset mid-flight: 2 outstanding, assert rst 1 cycle, then deliver stale R id 0 -> all outputs 0, no response, new request id 0 accepted normally.
